// File: rtl/pending_txn_table_if.sv
// Insert/query/delete bus between the wb2noc/noc2wb logic and the
// pending-transaction table.
interface pending_txn_table_if #(
  parameter int unsigned N_BITS_SRC  = 4,
  parameter int unsigned N_BITS_DEST = 4,
  parameter int unsigned N_BITS_CMD  = 3
);
  logic                   new_pending_transaction_i;
  logic [N_BITS_SRC-1:0]  new_sender_i;
  logic [N_BITS_DEST-1:0] new_recipient_i;
  logic [N_BITS_CMD-1:0]  new_transaction_type_i;
  logic                   query_i;
  logic [N_BITS_SRC-1:0]  query_sender_i;
  logic [N_BITS_DEST-1:0] query_recipient_i;
  logic [N_BITS_CMD-1:0]  query_transaction_type_i;
  logic                   delete_transaction_i;
  logic                   is_a_pending_transaction_o;

  modport master (
    output new_pending_transaction_i, new_sender_i, new_recipient_i, new_transaction_type_i,
    output query_i, query_sender_i, query_recipient_i, query_transaction_type_i,
    output delete_transaction_i,
    input  is_a_pending_transaction_o
  );

  modport slave (
    input  new_pending_transaction_i, new_sender_i, new_recipient_i, new_transaction_type_i,
    input  query_i, query_sender_i, query_recipient_i, query_transaction_type_i,
    input  delete_transaction_i,
    output is_a_pending_transaction_o
  );
endinterface

// File: rtl/pending_txn_table.sv
// Pending-transaction table: one entry per outstanding node-to-NoC request,
// matched and retired by (sender, recipient, type), with registered status
// and per-entry timeout eviction.
module pending_txn_table #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned N_BITS_SRC     = 4,
  parameter int unsigned N_BITS_DEST    = 4,
  parameter int unsigned N_BITS_CMD     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned N_BITS_POINTER = $clog2(DEPTH),
  parameter int unsigned N_BITS_OCC     = $clog2(DEPTH + 1),
  parameter int unsigned N_BITS_AGE     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  pending_txn_table_if.slave     bus,
  output logic                   insert_error_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [N_BITS_OCC-1:0]  occupancy_o,
  output logic                   timeout_o,
  output logic [N_BITS_SRC-1:0]  timeout_sender_o,
  output logic [N_BITS_DEST-1:0] timeout_recipient_o,
  output logic [N_BITS_CMD-1:0]  timeout_type_o
);

  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       valid_n;
  logic [N_BITS_SRC-1:0]  src_q  [DEPTH];
  logic [N_BITS_DEST-1:0] dest_q [DEPTH];
  logic [N_BITS_CMD-1:0]  cmd_q  [DEPTH];

  logic [DEPTH-1:0]          match;
  logic [DEPTH-1:0]          del_oh;
  logic [DEPTH-1:0]          exp_vec;
  logic [DEPTH-1:0]          evict_oh;
  logic [DEPTH-1:0]          ins_oh;
  logic                      evict_any;
  logic [N_BITS_POINTER-1:0] evict_idx;
  logic [N_BITS_OCC-1:0]     occ_n;

  // Per-entry exact match against the query fields.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = valid_q[i]
              && (src_q[i]  == bus.query_sender_i)
              && (dest_q[i] == bus.query_recipient_i)
              && (cmd_q[i]  == bus.query_transaction_type_i);
    end
  end

  assign bus.is_a_pending_transaction_o = bus.query_i && (|match);

  // Pick delete, eviction and insert slots (lowest index wins) and form next valid state.
  // Inserts only target slots invalid this cycle, so they never collide with delete/evict.
  always_comb begin
    logic del_found;
    logic ev_found;
    logic ins_found;
    del_oh    = '0;
    evict_oh  = '0;
    ins_oh    = '0;
    evict_any = 1'b0;
    evict_idx = '0;
    del_found = 1'b0;
    ev_found  = 1'b0;
    ins_found = 1'b0;
    occ_n     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!del_found && bus.query_i && bus.delete_transaction_i && match[i]) begin
        del_oh[i] = 1'b1;
        del_found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ev_found && exp_vec[i] && !del_oh[i]) begin
        evict_oh[i] = 1'b1;
        evict_idx   = N_BITS_POINTER'(i);
        ev_found    = 1'b1;
      end
    end
    evict_any = ev_found;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!ins_found && bus.new_pending_transaction_i && !valid_q[i]) begin
        ins_oh[i] = 1'b1;
        ins_found = 1'b1;
      end
    end
    valid_n = (valid_q & ~del_oh & ~evict_oh) | ins_oh;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      occ_n = occ_n + N_BITS_OCC'(valid_n[i]);
    end
  end

  // Entry payload capture on insert; payload is qualified by the valid bit.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ins_oh[i]) begin
        src_q[i]  <= bus.new_sender_i;
        dest_q[i] <= bus.new_recipient_i;
        cmd_q[i]  <= bus.new_transaction_type_i;
      end
    end
  end

  // Valid bits, registered status and one-cycle event pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q             <= '0;
      occupancy_o         <= '0;
      full_o              <= 1'b0;
      empty_o             <= 1'b1;
      insert_error_o      <= 1'b0;
      timeout_o           <= 1'b0;
      timeout_sender_o    <= '0;
      timeout_recipient_o <= '0;
      timeout_type_o      <= '0;
    end else begin
      valid_q        <= valid_n;
      occupancy_o    <= occ_n;
      full_o         <= (occ_n == N_BITS_OCC'(DEPTH));
      empty_o        <= (occ_n == '0);
      insert_error_o <= bus.new_pending_transaction_i && (&valid_q);
      timeout_o      <= evict_any;
      if (evict_any) begin
        timeout_sender_o    <= src_q[evict_idx];
        timeout_recipient_o <= dest_q[evict_idx];
        timeout_type_o      <= cmd_q[evict_idx];
      end
    end
  end

  if (TIMEOUT_CYCLES > 0) begin : g_age
    localparam logic [N_BITS_AGE-1:0] AGE_MAX = N_BITS_AGE'(TIMEOUT_CYCLES - 1);
    localparam logic [N_BITS_AGE-1:0] AGE_ONE = N_BITS_AGE'(1);
    logic [N_BITS_AGE-1:0] age_q [DEPTH];

    // Saturating per-entry age; restarts at zero on insert and stays zero while free.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (ins_oh[i] || !valid_q[i]) age_q[i] <= '0;
          else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + AGE_ONE;
        end
      end
    end

    // An entry is expired once its age has saturated.
    always_comb begin
      exp_vec = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        exp_vec[i] = valid_q[i] && (age_q[i] == AGE_MAX);
      end
    end
  end else begin : g_no_age
    assign exp_vec = '0;
  end

endmodule

// File: tb/tb_pending_txn_table.sv
// Directed bench for pending_txn_table (DEPTH=4, TIMEOUT_CYCLES=8).
module tb_pending_txn_table;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       insert_error;
  logic       full;
  logic       empty;
  logic [2:0] occupancy;
  logic       timeout;
  logic [3:0] timeout_sender;
  logic [3:0] timeout_recipient;
  logic [2:0] timeout_type;

  int total = 0;
  int bad   = 0;

  pending_txn_table_if #(.N_BITS_SRC(4), .N_BITS_DEST(4), .N_BITS_CMD(3)) bus ();

  pending_txn_table #(
    .DEPTH(4), .N_BITS_SRC(4), .N_BITS_DEST(4), .N_BITS_CMD(3), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .bus                 (bus),
    .insert_error_o      (insert_error),
    .full_o              (full),
    .empty_o             (empty),
    .occupancy_o         (occupancy),
    .timeout_o           (timeout),
    .timeout_sender_o    (timeout_sender),
    .timeout_recipient_o (timeout_recipient),
    .timeout_type_o      (timeout_type)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.new_pending_transaction_i = 1'b0;
    bus.new_sender_i              = '0;
    bus.new_recipient_i           = '0;
    bus.new_transaction_type_i    = '0;
    bus.query_i                   = 1'b0;
    bus.query_sender_i            = '0;
    bus.query_recipient_i         = '0;
    bus.query_transaction_type_i  = '0;
    bus.delete_transaction_i      = 1'b0;
  endtask

  task automatic set_insert(input logic [3:0] s, input logic [3:0] d, input logic [2:0] c);
    bus.new_pending_transaction_i = 1'b1;
    bus.new_sender_i              = s;
    bus.new_recipient_i           = d;
    bus.new_transaction_type_i    = c;
  endtask

  task automatic set_query(input logic [3:0] s, input logic [3:0] d, input logic [2:0] c,
                           input logic del);
    bus.query_i                  = 1'b1;
    bus.query_sender_i           = s;
    bus.query_recipient_i        = d;
    bus.query_transaction_type_i = c;
    bus.delete_transaction_i     = del;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    tick();
    set_query(4'd0, 4'd0, 3'd0, 1'b0);
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ: got %0d expected 0", occupancy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b expected 0", full); end
    total++; if (insert_error !== 1'b0) begin bad++; $display("FAIL reset_ins_err: got %b expected 0", insert_error); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    total++; if ({timeout_sender, timeout_recipient, timeout_type} !== 11'd0) begin bad++; $display("FAIL reset_to_fields: got %h expected 0", {timeout_sender, timeout_recipient, timeout_type}); end
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL reset_pending: got %b expected 0", bus.is_a_pending_transaction_o); end
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_insert_query();
    set_insert(4'd1, 4'd2, 3'd3); tick();
    set_insert(4'd4, 4'd5, 3'd6); tick();
    clear_inputs();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL iq_occ: got %0d expected 2", occupancy); end
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL iq_empty: got %b expected 0", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL iq_full: got %b expected 0", full); end
    set_query(4'd4, 4'd5, 3'd6, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL iq_hit: got %b expected 1", bus.is_a_pending_transaction_o); end
    set_query(4'd4, 4'd5, 3'd7, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL iq_miss_type: got %b expected 0", bus.is_a_pending_transaction_o); end
    set_query(4'd1, 4'd2, 3'd3, 1'b0); bus.query_i = 1'b0; #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL iq_no_strobe: got %b expected 0", bus.is_a_pending_transaction_o); end
    set_query(4'd9, 4'd9, 3'd1, 1'b1); tick();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL iq_del_nomatch: got %0d expected 2", occupancy); end
    set_query(4'd1, 4'd2, 3'd3, 1'b1); tick();
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL iq_del1: got %0d expected 1", occupancy); end
    set_query(4'd4, 4'd5, 3'd6, 1'b1); tick();
    clear_inputs();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL iq_del2: got %0d expected 0", occupancy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL iq_empty_end: got %b expected 1", empty); end
  endtask

  task automatic test_full();
    set_insert(4'd1, 4'd1, 3'd1); tick();
    set_insert(4'd2, 4'd2, 3'd2); tick();
    set_insert(4'd3, 4'd3, 3'd3); tick();
    set_insert(4'd4, 4'd4, 3'd4); tick();
    clear_inputs();
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_set: got %b expected 1", full); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ: got %0d expected 4", occupancy); end
    total++; if (insert_error !== 1'b0) begin bad++; $display("FAIL full_no_err: got %b expected 0", insert_error); end
    set_insert(4'd5, 4'd5, 3'd5); tick();
    total++; if (insert_error !== 1'b1) begin bad++; $display("FAIL overflow_err: got %b expected 1", insert_error); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL overflow_occ: got %0d expected 4", occupancy); end
    set_insert(4'd6, 4'd6, 3'd6); set_query(4'd1, 4'd1, 3'd1, 1'b1); tick();
    clear_inputs();
    total++; if (insert_error !== 1'b1) begin bad++; $display("FAIL ins_del_err: got %b expected 1", insert_error); end
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL ins_del_occ: got %0d expected 3", occupancy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL ins_del_full: got %b expected 0", full); end
    set_query(4'd2, 4'd2, 3'd2, 1'b1); tick();
    total++; if (insert_error !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %b expected 0", insert_error); end
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL full_del2_occ: got %0d expected 2", occupancy); end
    set_query(4'd6, 4'd6, 3'd6, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL dropped_absent: got %b expected 0", bus.is_a_pending_transaction_o); end
    set_query(4'd5, 4'd5, 3'd5, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL overflow_absent: got %b expected 0", bus.is_a_pending_transaction_o); end
    set_query(4'd3, 4'd3, 3'd3, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL kept_present: got %b expected 1", bus.is_a_pending_transaction_o); end
    set_query(4'd3, 4'd3, 3'd3, 1'b1); tick();
    set_query(4'd4, 4'd4, 3'd4, 1'b1); tick();
    clear_inputs();
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL full_drain_occ: got %0d expected 0", occupancy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL full_no_timeout: got %b expected 0", timeout); end
  endtask

  task automatic test_timeout();
    set_insert(4'd2, 4'd3, 3'd1); tick();
    clear_inputs();
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early_%0d: got %b expected 0", k, timeout); end
    end
    tick();
    set_query(4'd2, 4'd3, 3'd1, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL to_final_match: got %b expected 1", bus.is_a_pending_transaction_o); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL to_final_occ: got %0d expected 1", occupancy); end
    clear_inputs();
    tick();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_pulse: got %b expected 1", timeout); end
    total++; if ({timeout_sender, timeout_recipient, timeout_type} !== {4'd2, 4'd3, 3'd1}) begin bad++; $display("FAIL to_fields: got %h expected %h", {timeout_sender, timeout_recipient, timeout_type}, {4'd2, 4'd3, 3'd1}); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL to_occ: got %0d expected 0", occupancy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL to_empty: got %b expected 1", empty); end
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_pulse_end: got %b expected 0", timeout); end
    total++; if ({timeout_sender, timeout_recipient, timeout_type} !== {4'd2, 4'd3, 3'd1}) begin bad++; $display("FAIL to_fields_hold: got %h expected %h", {timeout_sender, timeout_recipient, timeout_type}, {4'd2, 4'd3, 3'd1}); end
  endtask

  task automatic test_delete_on_expiry();
    set_insert(4'd7, 4'd1, 3'd2); tick();
    clear_inputs();
    repeat (7) tick();
    set_query(4'd7, 4'd1, 3'd2, 1'b1); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL de_match: got %b expected 1", bus.is_a_pending_transaction_o); end
    tick();
    clear_inputs();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL de_no_timeout: got %b expected 0", timeout); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL de_occ: got %0d expected 0", occupancy); end
    total++; if (timeout_sender !== 4'd2) begin bad++; $display("FAIL de_fields_hold: got %0d expected 2", timeout_sender); end
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL de_no_timeout_late: got %b expected 0", timeout); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL de_occ_late: got %0d expected 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    set_insert(4'd1, 4'd0, 3'd1); tick();
    set_insert(4'd2, 4'd0, 3'd2); tick();
    clear_inputs();
    repeat (6) tick();
    total++; if (occupancy !== 3'd2) begin bad++; $display("FAIL b2b_occ: got %0d expected 2", occupancy); end
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL b2b_pre: got %b expected 0", timeout); end
    tick();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL b2b_first: got %b expected 1", timeout); end
    total++; if ({timeout_sender, timeout_recipient, timeout_type} !== {4'd1, 4'd0, 3'd1}) begin bad++; $display("FAIL b2b_first_fields: got %h expected %h", {timeout_sender, timeout_recipient, timeout_type}, {4'd1, 4'd0, 3'd1}); end
    total++; if (occupancy !== 3'd1) begin bad++; $display("FAIL b2b_first_occ: got %0d expected 1", occupancy); end
    tick();
    total++; if (timeout !== 1'b1) begin bad++; $display("FAIL b2b_second: got %b expected 1", timeout); end
    total++; if ({timeout_sender, timeout_recipient, timeout_type} !== {4'd2, 4'd0, 3'd2}) begin bad++; $display("FAIL b2b_second_fields: got %h expected %h", {timeout_sender, timeout_recipient, timeout_type}, {4'd2, 4'd0, 3'd2}); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty: got %b expected 1", empty); end
    tick();
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b expected 0", timeout); end
  endtask

  task automatic test_async_reset();
    set_insert(4'd8, 4'd9, 3'd4); tick();
    set_insert(4'd10, 4'd11, 3'd5); tick();
    set_insert(4'd12, 4'd13, 3'd6); tick();
    clear_inputs();
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL ar_pre_occ: got %0d expected 3", occupancy); end
    set_query(4'd8, 4'd9, 3'd4, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL ar_occ: got %0d expected 0", occupancy); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_empty: got %b expected 1", empty); end
    total++; if (timeout_sender !== 4'd0) begin bad++; $display("FAIL ar_to_sender: got %0d expected 0", timeout_sender); end
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL ar_pending: got %b expected 0", bus.is_a_pending_transaction_o); end
    clear_inputs();
    tick();
    rst = 1'b1;
    tick();
    set_query(4'd8, 4'd9, 3'd4, 1'b0); #1;
    total++; if (bus.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL ar_post_query: got %b expected 0", bus.is_a_pending_transaction_o); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL ar_post_occ: got %0d expected 0", occupancy); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_insert_query();
    test_full();
    test_timeout();
    test_delete_on_expiry();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pending_txn_table.md
Name: pending_txn_table

Overview:
Parametrised successor to the NIC's on-the-fly node-to-NoC pending-transaction table. wb2noc inserts one entry per outstanding request. noc2wb queries by (sender, recipient, type) and deletes the entry on completion. Unlike the fixed table, it has configurable depth and field widths, occupancy/full/empty status, insert-overflow error reporting, and per-entry timeout eviction so lost responses cannot leak slots.

Parameters:
DEPTH, 8, number of entries (>=2)
N_BITS_SRC, 4, sender field width
N_BITS_DEST, 4, recipient field width
N_BITS_CMD, 3, transaction-type field width
TIMEOUT_CYCLES, 1024, entry lifetime in cycles; 0 disables timeout
N_BITS_POINTER, clog2(DEPTH), entry index width
N_BITS_OCC, clog2(DEPTH+1), occupancy width
N_BITS_AGE, clog2(TIMEOUT_CYCLES+1), age counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
new_pending_transaction_i  in  1  insert request
new_sender_i  in  N_BITS_SRC  insert sender
new_recipient_i  in  N_BITS_DEST  insert recipient
new_transaction_type_i  in  N_BITS_CMD  insert type
query_i  in  1  query strobe
query_sender_i  in  N_BITS_SRC  query sender
query_recipient_i  in  N_BITS_DEST  query recipient
query_transaction_type_i  in  N_BITS_CMD  query type
delete_transaction_i  in  1  delete matched entry (valid only with query_i)
is_a_pending_transaction_o  out  1  combinational match result
insert_error_o  out  1  registered one-cycle pulse: insert dropped (table full)
full_o  out  1  all entries valid
empty_o  out  1  no entry valid
occupancy_o  out  N_BITS_OCC  count of valid entries
timeout_o  out  1  registered one-cycle pulse: an entry expired
timeout_sender_o  out  N_BITS_SRC  expired entry sender
timeout_recipient_o  out  N_BITS_DEST  expired entry recipient
timeout_type_o  out  N_BITS_CMD  expired entry type

Behaviour:
- Per entry: valid bit, src/dest/cmd fields, age counter.
- Reset (rst=0, async):
  - all valid bits and ages cleared
  - insert_error_o=0, timeout_o=0, timeout_* fields=0
  - full_o=0, empty_o=1, occupancy_o=0
  - is_a_pending_transaction_o=0
  - Mid-operation reset discards all entries immediately.
- Query:
  - is_a_pending_transaction_o = query_i AND some valid entry equals all three fields exactly.
  - Zero latency: combinational from inputs and current state.
  - With query_i=0 it is 0.
- Delete:
  - If query_i && delete_transaction_i && match, the lowest-index matching entry is cleared at the next edge.
  - Delete with no match: no state change, no error.
- Insert:
  - On new_pending_transaction_i, the lowest-index entry that is invalid at the current cycle is written at the next edge with age=0.
  - If full_o=1 the insert is dropped and insert_error_o=1 for exactly the following cycle.
  - A slot freed by delete or expiry in the same cycle is not reusable until the next cycle, so an insert while full with a simultaneous delete is still dropped.
  - Duplicates are allowed; delete removes one copy (lowest index).
- Age/timeout (TIMEOUT_CYCLES>0):
  - Each valid entry's age increments every cycle.
  - It saturates at TIMEOUT_CYCLES-1; an entry at that value is "expired".
  - Each cycle, the lowest-index expired entry not being deleted that cycle is cleared at the next edge.
  - timeout_o pulses in the following cycle with that entry's fields.
  - Other expired entries wait, one eviction per cycle, in index order.
  - Delete has priority over expiry for the same entry; no timeout is reported for it.
  - An expiring entry still matches a query in its final cycle.
  - Timeout fields hold their last value when timeout_o=0.
- TIMEOUT_CYCLES=0: no age logic; timeout_o stays 0.
- Status outputs are registered and reflect table state after the edge:
  - occupancy_o = valid count
  - full_o = (occupancy==DEPTH)
  - empty_o = (occupancy==0)
  - Net change per cycle: +1 insert, -1 delete, -1 expiry; all three may occur in the same cycle.

Test Plan:
- DEPTH=4: reset, insert (1,2,3) then (4,5,6); query (4,5,6) -> is_a_pending=1; query (4,5,7) -> 0; occupancy_o=2, empty_o=0.
- DEPTH=4: insert 4 entries -> full_o=1; 5th insert -> insert_error_o=1 for one cycle, occupancy stays 4. Insert plus matching delete in the same cycle -> insert dropped, occupancy=3.
- TIMEOUT_CYCLES=8: insert (2,3,1) and no delete -> timeout_o=1 with fields (2,3,1) after eviction; occupancy returns to 0.
- TIMEOUT_CYCLES=8: on the last age cycle of an entry, query+delete it -> no timeout_o, occupancy decrements once.
- Two entries inserted in the same-age window (back-to-back cycles, then a stall so both expire together) -> timeout_o pulses on consecutive cycles, lower index first.
- With 3 entries valid, drive rst=0 asynchronously mid-cycle -> outputs go to reset values immediately; a query after release returns 0.
